// File: rtl/home_tracker_pkg.sv
// Shared types for the home tracker: FSM state enum built on the common encodings.
`include "home_tracker_defs.vh"

package home_tracker_pkg;
  typedef enum logic [1:0] {
    ST_HOME = `HT_HOME,
    ST_AWAY = `HT_AWAY,
    ST_REST = `HT_REST,
    ST_BAD  = 2'd3
  } ht_state_e;
endpackage

// File: rtl/home_tracker_defs.vh
// State encodings of the home tracker FSM, shared by the package and any status/report logic.
`ifndef HOME_TRACKER_DEFS_VH
`define HOME_TRACKER_DEFS_VH
`define HT_HOME 2'd0
`define HT_AWAY 2'd1
`define HT_REST 2'd2
`endif

// File: rtl/sat_counter.sv
// Saturating up-counter: clear, load-to-1 and increment that sticks at MAX.
module sat_counter #(
  parameter int          W   = 8,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load1,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk) begin
    if (rst || clr)             cnt <= '0;
    else if (load1)             cnt <= W'(1);
    else if (inc && cnt < MAX)  cnt <= cnt + W'(1);
  end
endmodule

// File: rtl/home_tracker.sv
// Watches the schedule FSM's home/tired outputs: trip timing, day count and
// rest enforcement after a run of tired arrivals.
module home_tracker
  import home_tracker_pkg::*;
#(
  parameter int AWAY_W      = 8,
  parameter int DAY_W       = 8,
  parameter int TIRED_LIMIT = 3,
  parameter int REST_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              home,
  input  logic              tired,
  output logic              leave,
  output logic              arrive,
  output logic [AWAY_W-1:0] away_cnt,
  output logic [AWAY_W-1:0] last_away,
  output logic [DAY_W-1:0]  days,
  output logic              rest_req,
  output logic [1:0]        state
);
  localparam int SW = $clog2(TIRED_LIMIT + 1);
  localparam int TW = $clog2(REST_CYCLES + 1);

  ht_state_e     st;
  logic          home_d;
  logic [SW-1:0] streak;
  logic [TW-1:0] rest_tmr;
  logic          depart, arrival, streak_hit, rest_done;

  // Leaving REST early counts as a normal departure.
  assign depart     = !home && (st == ST_HOME || st == ST_REST);
  assign arrival    = home && !home_d && (st == ST_AWAY);
  assign streak_hit = tired && (32'(streak) + 1 >= TIRED_LIMIT);
  assign rest_done  = (st == ST_REST) && home && (rest_tmr == TW'(1));

  sat_counter #(.W(AWAY_W)) u_away (
    .clk   (clk),
    .rst   (rst),
    .clr   (arrival || st == ST_BAD),
    .load1 (depart),
    .inc   (st == ST_AWAY && !home),
    .cnt   (away_cnt)
  );

  sat_counter #(.W(SW), .MAX(SW'(TIRED_LIMIT))) u_streak (
    .clk   (clk),
    .rst   (rst),
    .clr   ((arrival && !tired) || rest_done),
    .load1 (1'b0),
    .inc   (arrival && tired),
    .cnt   (streak)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= ST_HOME;
      home_d    <= 1'b1;
      leave     <= 1'b0;
      arrive    <= 1'b0;
      last_away <= '0;
      days      <= '0;
      rest_req  <= 1'b0;
      rest_tmr  <= '0;
    end else begin
      home_d <= home;
      leave  <= depart;
      arrive <= arrival;
      case (st)
        ST_HOME: if (!home) st <= ST_AWAY;
        ST_AWAY: begin
          if (arrival) begin
            last_away <= away_cnt;
            days      <= days + DAY_W'(1);
            if (streak_hit) begin
              st       <= ST_REST;
              rest_req <= 1'b1;
              rest_tmr <= TW'(REST_CYCLES);
            end else begin
              st <= ST_HOME;
            end
          end
        end
        ST_REST: begin
          // rest_req deliberately survives a violation; only a full countdown clears it.
          if (home) begin
            rest_tmr <= rest_tmr - TW'(1);
            if (rest_done) begin
              st       <= ST_HOME;
              rest_req <= 1'b0;
            end
          end else begin
            st       <= ST_AWAY;
            rest_tmr <= '0;
          end
        end
        default: st <= ST_HOME;
      endcase
    end
  end

  assign state = st;
endmodule

// File: tb/tb_home_tracker.sv
// Directed scenarios plus a randomized run against a trip/rest reference model.
module tb_home_tracker;
  localparam int AW = 4, DW = 8, LIM = 3, RC = 4;
  localparam int AMAX = 15, DMOD = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b1, home = 1'b1, tired = 1'b0;
  logic          leave, arrive, rest_req;
  logic [AW-1:0] away_cnt, last_away;
  logic [DW-1:0] days;
  logic [1:0]    state;

  int n_checks = 0, n_fail = 0;
  int m_loc, m_trip, m_last, m_days, m_streak, m_rtime, m_req, m_leave, m_arrive;

  home_tracker #(.AWAY_W(AW), .DAY_W(DW), .TIRED_LIMIT(LIM), .REST_CYCLES(RC)) dut (
    .clk(clk), .rst(rst), .home(home), .tired(tired), .leave(leave), .arrive(arrive),
    .away_cnt(away_cnt), .last_away(last_away), .days(days), .rest_req(rest_req), .state(state)
  );

  always #5 clk = ~clk;

  // Reference: location 0=home 1=away 2=resting; trip length, days and rest in plain ints.
  task automatic model(input logic h, input logic t, input logic r);
    if (r) begin
      m_loc = 0; m_trip = 0; m_last = 0; m_days = 0; m_streak = 0;
      m_rtime = 0; m_req = 0; m_leave = 0; m_arrive = 0;
      return;
    end
    m_leave = 0; m_arrive = 0;
    if (m_loc == 1) begin
      if (!h) m_trip = (m_trip < AMAX) ? m_trip + 1 : AMAX;
      else begin
        m_arrive = 1; m_last = m_trip; m_trip = 0; m_days = (m_days + 1) % DMOD;
        m_streak = t ? ((m_streak < LIM) ? m_streak + 1 : LIM) : 0;
        if (m_streak >= LIM) begin m_loc = 2; m_req = 1; m_rtime = RC; end
        else m_loc = 0;
      end
    end else if (!h) begin
      m_loc = 1; m_leave = 1; m_trip = 1; m_rtime = 0;
    end else if (m_loc == 2) begin
      m_rtime = m_rtime - 1;
      if (m_rtime == 0) begin m_loc = 0; m_req = 0; m_streak = 0; end
    end
  endtask

  task automatic step(input logic h, input logic t, input logic r);
    home = h; tired = t; rst = r;
    @(posedge clk);
    model(h, t, r);
    #1;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
  endtask

  task automatic trip(input int away, input logic t);
    for (int i = 0; i < away; i++) step(1'b0, 1'b0, 1'b0);
    step(1'b1, t, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({leave, arrive, away_cnt, last_away, days, rest_req} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %b required all zero", {leave, arrive, away_cnt, last_away, days, rest_req});
    end
    n_checks++;
    if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d required 0", state); end
    step(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (leave !== 1'b1 || state !== 2'd1) begin
      n_fail++; $display("FAIL leave_after_reset: leave=%b state=%0d required 1/1", leave, state);
    end
    step(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (leave !== 1'b0) begin n_fail++; $display("FAIL leave_one_cycle: got %b required 0", leave); end
  endtask

  task automatic test_trip();
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (away_cnt !== 4'd5) begin n_fail++; $display("FAIL away_count: got %0d required 5", away_cnt); end
    step(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (arrive !== 1'b1 || last_away !== 4'd5 || days !== 8'd1 || away_cnt !== 4'd0 || state !== 2'd0) begin
      n_fail++;
      $display("FAIL arrival: arrive=%b last=%0d days=%0d away=%0d state=%0d required 1/5/1/0/0",
               arrive, last_away, days, away_cnt, state);
    end
    step(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (arrive !== 1'b0) begin n_fail++; $display("FAIL arrive_one_cycle: got %b required 0", arrive); end
  endtask

  task automatic test_tired_rest();
    do_reset();
    trip(2, 1'b1);
    trip(2, 1'b1);
    n_checks++;
    if (rest_req !== 1'b0 || state !== 2'd0) begin
      n_fail++; $display("FAIL rest_early: rest_req=%b state=%0d required 0/0", rest_req, state);
    end
    trip(2, 1'b1);
    n_checks++;
    if (arrive !== 1'b1 || rest_req !== 1'b1 || state !== 2'd2) begin
      n_fail++; $display("FAIL rest_enter: arrive=%b rest_req=%b state=%0d required 1/1/2", arrive, rest_req, state);
    end
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (rest_req !== 1'b1 || state !== 2'd2) begin
      n_fail++; $display("FAIL rest_hold: rest_req=%b state=%0d required 1/2", rest_req, state);
    end
    step(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (rest_req !== 1'b0 || state !== 2'd0) begin
      n_fail++; $display("FAIL rest_clear: rest_req=%b state=%0d required 0/0", rest_req, state);
    end
  endtask

  task automatic test_rest_violate();
    do_reset();
    for (int i = 0; i < 3; i++) trip(1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (leave !== 1'b1 || state !== 2'd1 || rest_req !== 1'b1 || away_cnt !== 4'd1) begin
      n_fail++;
      $display("FAIL rest_violate: leave=%b state=%0d rest_req=%b away=%0d required 1/1/1/1",
               leave, state, rest_req, away_cnt);
    end
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (arrive !== 1'b1 || state !== 2'd0 || rest_req !== 1'b1) begin
      n_fail++; $display("FAIL violate_return: arrive=%b state=%0d rest_req=%b required 1/0/1", arrive, state, rest_req);
    end
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (rest_req !== 1'b1) begin n_fail++; $display("FAIL rest_req_sticky: got %b required 1", rest_req); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (away_cnt !== 4'd15) begin n_fail++; $display("FAIL away_sat: got %0d required 15", away_cnt); end
    step(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (last_away !== 4'd15 || days !== 8'd1) begin
      n_fail++; $display("FAIL last_away_sat: last=%0d days=%0d required 15/1", last_away, days);
    end
    for (int i = 0; i < 254; i++) trip(1, 1'b0);
    n_checks++;
    if (days !== 8'd255) begin n_fail++; $display("FAIL days_255: got %0d required 255", days); end
    trip(1, 1'b0);
    n_checks++;
    if (days !== 8'd0) begin n_fail++; $display("FAIL days_wrap: got %0d required 0", days); end
  endtask

  task automatic test_reset_mid_trip();
    do_reset();
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (away_cnt !== 4'd7) begin n_fail++; $display("FAIL pre_reset_away: got %0d required 7", away_cnt); end
    step(1'b0, 1'b0, 1'b1);
    n_checks++;
    if (state !== 2'd0 || away_cnt !== 4'd0 || days !== 8'd0 || arrive !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_trip: state=%0d away=%0d days=%0d arrive=%b required 0/0/0/0",
               state, away_cnt, days, arrive);
    end
  endtask

  task automatic test_random();
    logic h = 1'b1;
    int   run = 0;
    logic [20:0] exp_v;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (run == 0) begin h = ~h; run = $urandom_range(1, 8); end
      run--;
      step(h, ($urandom_range(0, 9) < 7), ($urandom_range(0, 299) == 0));
      exp_v = {1'(m_leave), 1'(m_arrive), 4'(m_trip), 4'(m_last), 8'(m_days), 1'(m_req), 2'(m_loc)};
      n_checks++;
      if ({leave, arrive, away_cnt, last_away, days, rest_req, state} !== exp_v) begin
        n_fail++;
        $display("FAIL random cycle %0d: got %h required %h", i,
                 {leave, arrive, away_cnt, last_away, days, rest_req, state}, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_trip();
    test_tired_rest();
    test_rest_violate();
    test_saturation();
    test_reset_mid_trip();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
